// File: rtl/seg_scan_driver_if.sv
// Bus for the eight-digit seven-segment scan driver: calculator status and
// digit writes in, multiplexed anode/segment drive and error LED out.
interface seg_scan_driver_if;
  logic [1:0] status;
  logic [3:0] pos;
  logic [3:0] dig;
  logic [7:0] an;
  logic [6:0] seg;
  logic       err_led;

  modport master (output status, output pos, output dig,
                  input  an, input  seg, input  err_led);
  modport slave  (input  status, input  pos, input  dig,
                  output an, output seg, output err_led);
endinterface

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with a write buffer and error mode.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  seg_scan_driver_if.slave  bus
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] RCNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    ST_ERRO    = 2'd0,
    ST_PRONTA  = 2'd1,
    ST_OCUPADA = 2'd2,
    ST_RSVD    = 2'd3
  } status_e;

  logic [3:0]    dbuf_q [8];
  logic [3:0]    dbuf_d [8];
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [2:0]    sidx_q, sidx_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          err_led_q, err_led_d;
  logic          prev_ready_q, prev_ready_d;
  status_e       status;
  logic          ready_now;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  assign status    = status_e'(bus.status);
  // Reserved status code behaves exactly like PRONTA
  assign ready_now = (status == ST_PRONTA) || (status == ST_RSVD);

`ifdef LEADING_ZERO_BLANK_EN
  logic lead_zero;
`endif

  always_comb begin
    for (int i = 0; i < 8; i++) dbuf_d[i] = dbuf_q[i];
    if (status == ST_OCUPADA) begin
      if (prev_ready_q) begin
        for (int i = 0; i < 8; i++) dbuf_d[i] = 4'd0;
      end
      if (!bus.pos[3]) dbuf_d[bus.pos[2:0]] = bus.dig;
    end
    prev_ready_d = ready_now;

    rcnt_d = rcnt_q + 1'b1;
    sidx_d = sidx_q;
    if (rcnt_q == RCNT_MAX) begin
      rcnt_d = '0;
      sidx_d = sidx_q + 3'd1;
    end

    an_d      = ~(8'b1 << sidx_q);
    err_led_d = (status == ST_ERRO);
`ifdef LEADING_ZERO_BLANK_EN
    lead_zero = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if ((3'(i) <= sidx_q) && (dbuf_q[i] != 4'd0)) lead_zero = 1'b0;
    end
    if (status == ST_ERRO)                      seg_d = 7'h06;
    else if (lead_zero && (sidx_q != 3'd7))     seg_d = 7'h7F;
    else                                        seg_d = decode(dbuf_q[sidx_q]);
`else
    if (status == ST_ERRO) seg_d = 7'h06;
    else                   seg_d = decode(dbuf_q[sidx_q]);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) dbuf_q[i] <= 4'd0;
      rcnt_q       <= '0;
      sidx_q       <= 3'd0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      err_led_q    <= 1'b0;
      prev_ready_q <= 1'b1;
    end else begin
      for (int i = 0; i < 8; i++) dbuf_q[i] <= dbuf_d[i];
      rcnt_q       <= rcnt_d;
      sidx_q       <= sidx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      err_led_q    <= err_led_d;
      prev_ready_q <= prev_ready_d;
    end
  end

  assign bus.an      = an_q;
  assign bus.seg     = seg_q;
  assign bus.err_led = err_led_q;

endmodule
